memory_unit: RTL and testbench

- Data-memory subsystem for the MIPS pipeline's memory stage.
- Combines a 256×32 word-addressed RAM with three memory-mapped I/O registers:
  - two input ports, loaded from the external side;
  - one output port, written by the CPU.
- A single registered read path returns RAM or I/O data selected by a 10-bit byte address.

---
 rtl/memory_unit_pkg.sv | 29 ++
 rtl/memory_unit_if.sv | 23 ++
 rtl/memory_unit_ram.sv | 21 ++
 rtl/memory_unit.sv | 66 ++++++
 tb/tb_memory_unit.sv | 115 +++++++++++
 5 files changed

// File: rtl/memory_unit_pkg.sv
// Memory map shared by the data-memory subsystem: widths, I/O register
// addresses and the read-source select used by the registered read path.
package mem_map_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned WORD_WIDTH = ADDR_WIDTH - 2;
    localparam int unsigned RAM_DEPTH  = 2 ** WORD_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] INPORT0_ADDR = 10'h3F4;
    localparam logic [ADDR_WIDTH-1:0] INPORT1_ADDR = 10'h3F8;
    localparam logic [ADDR_WIDTH-1:0] OUTPORT_ADDR = 10'h3FC;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_IN0,
        SEL_IN1,
        SEL_OUT
    } rd_sel_t;

    // Decode operates on the word address; byte-offset bits never take part.
    function automatic rd_sel_t decode_sel(input logic [WORD_WIDTH-1:0] word);
        if (word == INPORT0_ADDR[ADDR_WIDTH-1:2]) return SEL_IN0;
        if (word == INPORT1_ADDR[ADDR_WIDTH-1:2]) return SEL_IN1;
        if (word == OUTPORT_ADDR[ADDR_WIDTH-1:2]) return SEL_OUT;
        return SEL_RAM;
    endfunction

endpackage

// File: rtl/memory_unit_if.sv
// CPU / external-side bus of the data-memory subsystem.
interface memory_unit_if;
    import mem_map_pkg::*;

    logic [ADDR_WIDTH-1:0] addr;
    logic                  write_en;
    logic                  en_0;
    logic                  en_1;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [DATA_WIDTH-1:0] output_port;

    modport master (
        output addr, write_en, en_0, en_1, data_in,
        input  data_out, output_port
    );

    modport slave (
        input  addr, write_en, en_0, en_1, data_in,
        output data_out, output_port
    );

endinterface

// File: rtl/memory_unit_ram.sv
// Single-port 256x32 RAM, synchronous write and read, read-before-write.
module ram_256x32
    import mem_map_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORD_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/memory_unit.sv
// Data-memory stage: RAM plus two input ports and one output port, with a
// one-cycle registered read path selected by the byte address.
module memory_unit
    import mem_map_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    memory_unit_if.slave bus
);

    logic [WORD_WIDTH-1:0] word_addr;
    logic [1:0]            unused_byte_offset;
    rd_sel_t               sel;
    rd_sel_t               sel_q;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] inport0;
    logic [DATA_WIDTH-1:0] inport1;
    logic [DATA_WIDTH-1:0] outport;
    logic [DATA_WIDTH-1:0] io_rd_q;

    assign word_addr          = bus.addr[ADDR_WIDTH-1:2];
    assign unused_byte_offset = bus.addr[1:0];
    assign sel                = decode_sel(word_addr);
    assign ram_we             = rst && bus.write_en && (sel == SEL_RAM);

    ram_256x32 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (word_addr),
        .wdata (bus.data_in),
        .rdata (ram_rdata)
    );

    // Reset parks the select on an I/O source holding zero, so data_out
    // reads 0 after reset without having to reset the RAM output register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inport0 <= '0;
            inport1 <= '0;
            outport <= '0;
            io_rd_q <= '0;
            sel_q   <= SEL_IN0;
        end else begin
            if (bus.en_0) inport0 <= bus.data_in;
            if (bus.en_1) inport1 <= bus.data_in;
            if (bus.write_en && (sel == SEL_OUT)) outport <= bus.data_in;
            sel_q <= sel;
            case (sel)
                SEL_IN0: io_rd_q <= inport0;
                SEL_IN1: io_rd_q <= inport1;
                SEL_OUT: io_rd_q <= outport;
                default: io_rd_q <= '0;
            endcase
        end
    end

    always_comb begin
        bus.data_out    = io_rd_q;
        bus.output_port = outport;
        if (sel_q == SEL_RAM) begin
            bus.data_out = ram_rdata;
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit: expected read data is queued as each step
// is driven and compared once the registered read result appears.
module tb_memory_unit;

    logic clk;
    logic rst;
    int unsigned total;
    int unsigned bad;
    logic [31:0] sb [$];

    memory_unit_if bus ();

    memory_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [9:0] a, input logic we, input logic e0, input logic e1,
                        input logic [31:0] d, input bit chk, input logic [31:0] exp,
                        input string tag);
        logic [31:0] want;
        bus.addr     = a;
        bus.write_en = we;
        bus.en_0     = e0;
        bus.en_1     = e1;
        bus.data_in  = d;
        if (chk) sb.push_back(exp);
        @(posedge clk);
        #1;
        if (chk) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s observed=empty_queue expected=entry", tag);
            end else begin
                want = sb.pop_front();
                check(tag, bus.data_out, want);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;

        step(10'h000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "rst0");
        step(10'h000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, "rst_data_out");
        check("rst_output_port", bus.output_port, 32'h0);

        rst = 1'b1;
        step(10'h000, 1'b1, 1'b0, 1'b0, 32'h12345678, 1'b0, 32'h0, "wr0");
        step(10'h000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678, "ram0_rd");

        step(10'h000, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 32'h12345678, "ld_in0");
        step(10'h3F4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "in0_rd");
        step(10'h3F4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "in0_wr_ignored");
        step(10'h3F4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "in0_unchanged");

        step(10'h3F8, 1'b0, 1'b0, 1'b1, 32'hCAFEBABE, 1'b1, 32'h0, "in1_rbw");
        step(10'h3F8, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFEBABE, "in1_rd");
        step(10'h3F4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, "in0_kept");

        step(10'h3FC, 1'b1, 1'b0, 1'b0, 32'hAABBCCDD, 1'b1, 32'h0, "out_rbw");
        check("out_port_wr", bus.output_port, 32'hAABBCCDD);
        step(10'h3FC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hAABBCCDD, "out_rd");
        step(10'h000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h12345678, "ram0_kept");

        step(10'h010, 1'b1, 1'b0, 1'b0, 32'h11111111, 1'b0, 32'h0, "wr10");
        step(10'h040, 1'b1, 1'b0, 1'b0, 32'h22222222, 1'b0, 32'h0, "wr40");
        step(10'h080, 1'b1, 1'b0, 1'b0, 32'h33333333, 1'b0, 32'h0, "wr80");
        step(10'h0C0, 1'b1, 1'b0, 1'b0, 32'h44444444, 1'b0, 32'h0, "wrC0");
        step(10'h010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h11111111, "rd10");
        step(10'h040, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h22222222, "rd40");
        step(10'h080, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h33333333, "rd80");
        step(10'h0C0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44444444, "rdC0");
        step(10'h012, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h11111111, "rd12_misaligned");

        step(10'h020, 1'b1, 1'b0, 1'b0, 32'h0BADF00D, 1'b0, 32'h0, "wr20_prior");
        step(10'h020, 1'b1, 1'b0, 1'b0, 32'h55555555, 1'b1, 32'h0BADF00D, "ram_rbw");
        step(10'h020, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h55555555, "ram_new");

        step(10'h3F4, 1'b0, 1'b1, 1'b1, 32'h77777777, 1'b1, 32'hDEADBEEF, "both_ld");
        step(10'h3F8, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h77777777, "both_in1");
        step(10'h3F4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h77777777, "both_in0");
        check("out_port_held", bus.output_port, 32'hAABBCCDD);

        rst = 1'b0;
        step(10'h3FC, 1'b1, 1'b1, 1'b0, 32'h99999999, 1'b1, 32'h0, "rst_mid_data");
        check("rst_mid_out_port", bus.output_port, 32'h0);
        step(10'h010, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0, "rst_ram_wr");
        rst = 1'b1;
        step(10'h010, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h11111111, "ram_wr_suppressed");
        step(10'h3F4, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, "in0_cleared");
        step(10'h3FC, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, "out_cleared");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
